// File: rtl/traffic_pkg.sv
// Shared types, lamp patterns and BCD helper
// for the two-road traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    EW_G  = 3'd2,
    EW_Y  = 3'd3,
    NIGHT = 3'd4
  } phase_e;

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] LED_NS_G = 6'b001_100;
  localparam logic [5:0] LED_NS_Y = 6'b010_100;
  localparam logic [5:0] LED_EW_G = 6'b100_001;
  localparam logic [5:0] LED_EW_Y = 6'b100_010;

  function automatic logic [7:0] to_bcd(
    input logic [6:0] v
  );
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {t, o};
  endfunction

  function automatic logic [5:0] led_of(
    input phase_e p,
    input logic   f
  );
    logic [5:0] l;
    case (p)
      NS_G:    l = LED_NS_G;
      NS_Y:    l = LED_NS_Y;
      EW_G:    l = LED_EW_G;
      EW_Y:    l = LED_EW_Y;
      default: l = {1'b0, f, 1'b0, 1'b0, f, 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_sched_key_debounce.sv
// Button conditioner: 2-flop sync, low-time
// counter, one press pulse per low period.
module key_debounce #(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          press_q, press_d;

  // Count consecutive low cycles, fire once, re-arm on release
  always_comb begin
    meta_d  = key_n;
    sync_d  = meta_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    press_d = 1'b0;
    if (sync_q) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        press_d = 1'b1;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle button reads high, so the sync chain resets high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road phase scheduler: tick divider,
// phase FSM, countdown and pedestrian shortening.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned GREEN_NS = 30,
  parameter int unsigned GREEN_EW = 20,
  parameter int unsigned YEL      = 3,
  parameter int unsigned PED_MIN  = 5,
  parameter int unsigned DEB_CYC  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_n,
  input  logic       night,
  output logic [5:0] led,
  output logic [7:0] cnt_bcd,
  output logic [2:0] phase
);

  localparam int unsigned DW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [6:0] C_GNS = 7'(GREEN_NS);
  localparam logic [6:0] C_GEW = 7'(GREEN_EW);
  localparam logic [6:0] C_YEL = 7'(YEL);
  localparam logic [6:0] C_PED = 7'(PED_MIN);

  logic [DW-1:0] div_q, div_d;
  logic          nmeta_q, nmeta_d;
  logic          nsync_q, nsync_d;
  logic          tick;
  logic          press;

  phase_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          flash_q, flash_d;
  logic          pend_q, pend_d;
  logic [5:0]    led_q, led_d;

  key_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_ped (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (ped_n),
    .press (press)
  );

  assign tick = (div_q == DW'(TICK_DIV - 1));

  // Free-running tick divider and night-level synchronizer
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    nmeta_d = night;
    nsync_d = nmeta_q;
  end

  // Tick divider and night sync registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      nmeta_q <= 1'b0;
      nsync_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      nmeta_q <= nmeta_d;
      nsync_q <= nsync_d;
    end
  end

  // Next phase/count; a tick always beats a pending shortening
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    pend_d  = pend_q | press;
    if (tick) begin
      unique case (state_q)
        NS_G: begin
          if (cnt_q == 7'd1) begin
            state_d = NS_Y;
            cnt_d   = C_YEL;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        NS_Y: begin
          if (cnt_q == 7'd1) begin
            if (nsync_q) begin
              state_d = NIGHT;
              cnt_d   = 7'd0;
              flash_d = 1'b1;
            end else begin
              state_d = EW_G;
              cnt_d   = C_GEW;
            end
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        EW_G: begin
          if (cnt_q == 7'd1) begin
            state_d = EW_Y;
            cnt_d   = C_YEL;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        EW_Y: begin
          if (cnt_q == 7'd1) begin
            if (nsync_q) begin
              state_d = NIGHT;
              cnt_d   = 7'd0;
              flash_d = 1'b1;
            end else begin
              state_d = NS_G;
              cnt_d   = C_GNS;
            end
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        NIGHT: begin
          if (!nsync_q) begin
            state_d = NS_G;
            cnt_d   = C_GNS;
            flash_d = 1'b0;
          end else begin
            flash_d = ~flash_q;
          end
        end
        default: begin
          state_d = NS_G;
          cnt_d   = C_GNS;
          flash_d = 1'b0;
        end
      endcase
    end else if (pend_q &&
                 (state_q == NS_G ||
                  state_q == EW_G)) begin
      if (cnt_q > C_PED) cnt_d = C_PED;
      pend_d = press;
    end
    if (state_q == NIGHT) pend_d = 1'b0;
    led_d = led_of(state_d, flash_d);
  end

  // Phase FSM with registered lamp outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NS_G;
      cnt_q   <= C_GNS;
      flash_q <= 1'b0;
      pend_q  <= 1'b0;
      led_q   <= LED_NS_G;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
    end
  end

  assign led     = led_q;
  assign phase   = state_q;
  assign cnt_bcd = to_bcd(cnt_q);

endmodule
